// File: rtl/reg_wb_scoreboard_pkg.sv
// Shared types for the register writeback controller and hazard scoreboard.
package reg_wb_pkg;

   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned DEF_LINK_REG = 31;

   // Writeback mux select driven to the register-file write port.
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2
   } wb_src_e;

   // One slot of the latency-matching delay line.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      wb_src_e               src;
   } wb_entry_t;

endpackage

// File: rtl/reg_wb_scoreboard_dest_decode.sv
// Decodes instruction class flags into the register-file destination,
// writeback source and which source fields the instruction reads.
module dest_decode
   import reg_wb_pkg::*;
#(
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned LINK_REG = DEF_LINK_REG
) (
   input  logic              alu_op,
   input  logic              imm_op,
   input  logic              mem_op,
   input  logic              write_op,
   input  logic              jump_op,
   input  logic              link_op,
   input  logic              reg_jump_op,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output wb_src_e           src,
   output logic              uses_rs,
   output logic              uses_rt
);

   // Priority-ordered destination select; register 0 is never written.
   always_comb begin
      we   = 1'b0;
      addr = '0;
      src  = WB_ALU;
      if (mem_op & ~write_op) begin
         we   = 1'b1;
         addr = rt;
         src  = WB_MEM;
      end else if (alu_op & imm_op) begin
         we   = 1'b1;
         addr = rt;
         src  = WB_ALU;
      end else if (jump_op & link_op & reg_jump_op) begin
         we   = 1'b1;
         addr = rd;
         src  = WB_PC;
      end else if (jump_op & link_op) begin
         we   = 1'b1;
         addr = ADDR_W'(LINK_REG);
         src  = WB_PC;
      end else if (alu_op) begin
         we   = 1'b1;
         addr = rd;
         src  = WB_ALU;
      end
      if (addr == '0) we = 1'b0;
   end

   // Source-operand usage for RAW hazard detection.
   always_comb begin
      uses_rs = alu_op | mem_op | reg_jump_op;
      uses_rt = (alu_op & ~imm_op) | (mem_op & write_op);
   end

endmodule

// File: rtl/reg_wb_scoreboard.sv
// Writeback controller: latency-matched delay line to the register-file
// write port plus a per-register busy scoreboard that stalls issue on
// RAW/WAW hazards and write-port collisions.
module reg_wb_scoreboard
   import reg_wb_pkg::*;
#(
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ALU_LAT  = 1,
   parameter int unsigned MEM_LAT  = 2,
   parameter int unsigned LINK_REG = DEF_LINK_REG
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              alu_op,
   input  logic              imm_op,
   input  logic              mem_op,
   input  logic              write_op,
   input  logic              jump_op,
   input  logic              link_op,
   input  logic              reg_jump_op,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   output logic              stall,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [1:0]        wb_src
);

   wb_entry_t           slot [MEM_LAT];
   logic [NUM_REGS-1:0] busy;
   logic [MEM_LAT:0]    slot_vld_ext;

   logic                dec_we;
   logic [ADDR_W-1:0]   dec_addr;
   wb_src_e             dec_src;
   logic                uses_rs;
   logic                uses_rt;
   logic                collide;
   logic                accept_wr;
   int unsigned         tgt_idx;

   dest_decode #(
      .ADDR_W   (ADDR_W),
      .LINK_REG (LINK_REG)
   ) u_dest_decode (
      .alu_op      (alu_op),
      .imm_op      (imm_op),
      .mem_op      (mem_op),
      .write_op    (write_op),
      .jump_op     (jump_op),
      .link_op     (link_op),
      .reg_jump_op (reg_jump_op),
      .rt          (rt),
      .rd          (rd),
      .we          (dec_we),
      .addr        (dec_addr),
      .src         (dec_src),
      .uses_rs     (uses_rs),
      .uses_rt     (uses_rt)
   );

   // Slot valid bits with a constant-zero top bit so the collision probe
   // can index one past the target slot for either latency.
   always_comb begin
      slot_vld_ext = '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) slot_vld_ext[i] = slot[i].valid;
   end

   // Hazard detection. The target slot is refilled by the shift at the same
   // edge, so the collision test looks at the entry that shifts into it.
   always_comb begin
      tgt_idx   = (dec_src == WB_MEM) ? MEM_LAT - 1 : ALU_LAT - 1;
      collide   = (dec_src == WB_MEM) ? slot_vld_ext[MEM_LAT] : slot_vld_ext[ALU_LAT];
      stall     = issue_valid &
                  ((uses_rs & busy[rs]) | (uses_rt & busy[rt]) |
                   (dec_we & (busy[dec_addr] | collide)));
      accept_wr = issue_valid & ~stall & dec_we;
   end

   // Delay-line shift/load and busy set/clear (set wins on the same address).
   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
         for (int unsigned i = 0; i < MEM_LAT; i++) slot[i] <= '0;
      end else begin
         for (int unsigned i = 0; i + 1 < MEM_LAT; i++) slot[i] <= slot[i+1];
         slot[MEM_LAT-1] <= '0;
         for (int unsigned i = 0; i < MEM_LAT; i++) begin
            if (accept_wr && i == tgt_idx)
               slot[i] <= '{valid: 1'b1, addr: dec_addr, src: dec_src};
         end
         if (slot[0].valid) busy[slot[0].addr] <= 1'b0;
         if (accept_wr) busy[dec_addr] <= 1'b1;
      end
   end

   // Write port is driven straight from the registered head slot.
   always_comb begin
      wb_en   = slot[0].valid;
      wb_addr = slot[0].addr;
      wb_src  = slot[0].src;
   end

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Self-checking bench for reg_wb_scoreboard: directed scenarios followed by
// random issue, checked against a writeback-cycle reservation model.
module tb_reg_wb_scoreboard;

   localparam int ALU_LAT = 1;
   localparam int MEM_LAT = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       issue_valid;
   logic       alu_op, imm_op, mem_op, write_op, jump_op, link_op, reg_jump_op;
   logic [4:0] rs, rt, rd;
   logic       stall;
   logic       wb_en;
   logic [4:0] wb_addr;
   logic [1:0] wb_src;

   reg_wb_scoreboard #(
      .ADDR_W   (5),
      .NUM_REGS (32),
      .ALU_LAT  (ALU_LAT),
      .MEM_LAT  (MEM_LAT),
      .LINK_REG (31)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .alu_op      (alu_op),
      .imm_op      (imm_op),
      .mem_op      (mem_op),
      .write_op    (write_op),
      .jump_op     (jump_op),
      .link_op     (link_op),
      .reg_jump_op (reg_jump_op),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .stall       (stall),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_src      (wb_src)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic alu, imm, mem, wr, jmp, lnk, rj;
      logic [4:0] rs, rt, rd;
   } instr_t;

   // A pending register write: destination, source and the cycle in which
   // it is presented on the write port.
   typedef struct {
      logic [4:0] addr;
      logic [1:0] src;
      int         w;
   } pend_t;

   pend_t pending[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   logic  exp_stall_last;
   logic  obs_stall, obs_wb_en;
   logic [4:0] obs_wb_addr;
   logic [1:0] obs_wb_src;
   int    ns;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic instr_t mk(input logic a, i, m, w, j, l, r,
                                 input logic [4:0] s, t, d);
      instr_t x;
      x.alu = a; x.imm = i; x.mem = m; x.wr = w; x.jmp = j; x.lnk = l; x.rj = r;
      x.rs = s; x.rt = t; x.rd = d;
      return x;
   endfunction

   function automatic instr_t op_alu(input logic [4:0] s, t, d);  return mk(1,0,0,0,0,0,0,s,t,d); endfunction
   function automatic instr_t op_load(input logic [4:0] s, t);    return mk(0,0,1,0,0,0,0,s,t,0); endfunction
   function automatic instr_t op_store(input logic [4:0] s, t);   return mk(0,0,1,1,0,0,0,s,t,0); endfunction
   function automatic instr_t op_jal();                           return mk(0,0,0,0,1,1,0,0,0,0); endfunction
   function automatic instr_t op_jalr(input logic [4:0] s, d);    return mk(0,0,0,0,1,1,1,s,0,d); endfunction
   function automatic instr_t op_j();                             return mk(0,0,0,0,1,0,0,0,0,0); endfunction

   // Reference decode written straight from the instruction-class table.
   task automatic ref_decode(input instr_t x, output logic we, output logic [4:0] a,
                             output logic [1:0] s, output logic urs, output logic urt);
      we = 1'b1; a = 5'd0; s = 2'd0;
      if (x.mem && !x.wr)               begin a = x.rt; s = 2'd1; end
      else if (x.alu && x.imm)          begin a = x.rt; s = 2'd0; end
      else if (x.jmp && x.lnk && x.rj)  begin a = x.rd; s = 2'd2; end
      else if (x.jmp && x.lnk)          begin a = 5'd31; s = 2'd2; end
      else if (x.alu)                   begin a = x.rd; s = 2'd0; end
      else                              we = 1'b0;
      if (a == 5'd0) we = 1'b0;
      urs = x.alu | x.mem | x.rj;
      urt = (x.alu & ~x.imm) | (x.mem & x.wr);
   endtask

   function automatic logic reg_busy(input logic [4:0] r);
      foreach (pending[k]) if (pending[k].addr == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic port_taken(input int w);
      foreach (pending[k]) if (pending[k].w == w) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: drive, check combinational stall and write port
   // against the model, then advance across the edge.
   task automatic step(input instr_t x, input logic v);
      logic we, urs, urt, e_stall, e_wb;
      logic [4:0] a, e_addr;
      logic [1:0] s, e_src;
      int lat;
      issue_valid = v;
      alu_op = x.alu; imm_op = x.imm; mem_op = x.mem; write_op = x.wr;
      jump_op = x.jmp; link_op = x.lnk; reg_jump_op = x.rj;
      rs = x.rs; rt = x.rt; rd = x.rd;
      #1;
      ref_decode(x, we, a, s, urs, urt);
      lat = (s == 2'd1) ? MEM_LAT : ALU_LAT;
      e_stall = v & ((urs & reg_busy(x.rs)) | (urt & reg_busy(x.rt)) |
                     (we & (reg_busy(a) | port_taken(cyc + lat))));
      e_wb = 1'b0; e_addr = 5'd0; e_src = 2'd0;
      foreach (pending[k]) if (pending[k].w == cyc) begin
         e_wb = 1'b1; e_addr = pending[k].addr; e_src = pending[k].src;
      end
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("wb_en", {31'd0, wb_en}, {31'd0, e_wb});
      if (e_wb) begin
         check("wb_addr", {27'd0, wb_addr}, {27'd0, e_addr});
         check("wb_src", {30'd0, wb_src}, {30'd0, e_src});
      end
      obs_stall = stall; obs_wb_en = wb_en; obs_wb_addr = wb_addr; obs_wb_src = wb_src;
      exp_stall_last = e_stall;
      @(posedge clock);
      if (v && !e_stall && we) pending.push_back('{a, s, cyc + lat});
      cyc++;
      pending = pending.find(p) with (p.w >= cyc);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(mk(0,0,0,0,0,0,0,0,0,0), 1'b0);
   endtask

   // Re-present an instruction until accepted; returns the stall count.
   task automatic issue(input instr_t x, output int stalls);
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         step(x, 1'b1);
         if (!exp_stall_last) return;
         stalls++;
      end
      checks++; errors++;
      $error("FAIL issue_timeout: observed still stalled after 20 cycles expected accept");
   endtask

   task automatic mid_reset();
      reset = 1'b1; issue_valid = 1'b0;
      @(posedge clock);
      pending.delete();
      cyc++;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; issue_valid = 1'b0;
      alu_op = 0; imm_op = 0; mem_op = 0; write_op = 0;
      jump_op = 0; link_op = 0; reg_jump_op = 0;
      rs = '0; rt = '0; rd = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_wb_en", {31'd0, wb_en}, 32'd0);
      check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      check("rst_wb_src", {30'd0, wb_src}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      reset = 1'b0;

      // ALU add rd=5, then an independent op, then a reader of r5.
      issue(op_alu(5'd1, 5'd2, 5'd5), ns);
      check("alu_stalls", ns, 0);
      step(op_alu(5'd3, 5'd4, 5'd6), 1'b1);
      check("alu_wb_en", {31'd0, obs_wb_en}, 32'd1);
      check("alu_wb_addr", {27'd0, obs_wb_addr}, 32'd5);
      check("alu_wb_src", {30'd0, obs_wb_src}, 32'd0);
      step(op_alu(5'd5, 5'd1, 5'd7), 1'b1);
      check("alu_busy_cleared", {31'd0, obs_stall}, 32'd0);
      idle(2);

      // Load-use: two stall cycles.
      issue(op_load(5'd1, 5'd8), ns);
      issue(op_alu(5'd8, 5'd2, 5'd10), ns);
      check("load_use_stalls", ns, 2);
      idle(2);

      // Load then independent ALU op: one port-collision stall.
      issue(op_load(5'd1, 5'd11), ns);
      issue(op_alu(5'd2, 5'd3, 5'd12), ns);
      check("collision_stalls", ns, 1);
      idle(3);

      // Links and non-writing instructions.
      issue(op_jal(), ns);
      issue(op_jalr(5'd1, 5'd3), ns);
      check("jal_wb_addr", {27'd0, obs_wb_addr}, 32'd31);
      check("jal_wb_src", {30'd0, obs_wb_src}, 32'd2);
      issue(op_store(5'd1, 5'd2), ns);
      check("jalr_wb_addr", {27'd0, obs_wb_addr}, 32'd3);
      issue(op_alu(5'd1, 5'd2, 5'd0), ns);
      check("store_no_wb", {31'd0, obs_wb_en}, 32'd0);
      issue(op_j(), ns);
      check("rd0_no_wb", {31'd0, obs_wb_en}, 32'd0);
      idle(1);
      check("j_no_wb", {31'd0, obs_wb_en}, 32'd0);
      idle(2);

      // WAW: back-to-back loads to r9.
      issue(op_load(5'd1, 5'd9), ns);
      issue(op_load(5'd2, 5'd9), ns);
      check("waw_stalls", ns, 2);
      idle(3);

      // Reset with a load in flight.
      issue(op_load(5'd1, 5'd13), ns);
      mid_reset();
      check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
      step(op_alu(5'd13, 5'd13, 5'd14), 1'b1);
      check("mid_rst_no_stall", {31'd0, obs_stall}, 32'd0);
      idle(2);

      // Random traffic over a small register window to provoke hazards.
      for (int k = 0; k < 400; k++) begin
         instr_t x;
         x = mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                $urandom_range(0,1), 5'($urandom_range(0,7)),
                5'($urandom_range(0,7)), 5'($urandom_range(0,7)));
         if (k == 250) mid_reset();
         step(x, ($urandom_range(0,3) != 0));
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_wb_scoreboard.md
# reg_wb_scoreboard

Parametrised writeback controller and hazard scoreboard for the pipelined MIPS core. It decodes each issued instruction's register-file destination (rd, rt or link register) and write enable, then carries the write through a latency-matched delay line to the register-file write port. A per-register busy scoreboard stalls issue on RAW/WAW hazards and on write-port collisions between paths of different latency. The block sits between decode/issue and the register-file write port.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count (2**ADDR_W)
- ALU_LAT, 1, cycles from issue to writeback for ALU and link results (>=1)
- MEM_LAT, 2, cycles from issue to writeback for loads (>=ALU_LAT)
- LINK_REG, 31, destination of jump-and-link

Ports (clock is `clock`, reset is `reset`: synchronous, active-high):
- clock  in  1  single clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction
- alu_op, imm_op, mem_op, write_op, jump_op, link_op, reg_jump_op  in  1 each  decoded class flags
- rs, rt, rd  in  ADDR_W each  instruction register fields
- stall  out  1  issue blocked this cycle (combinational)
- wb_en  out  1  register-file write enable (registered)
- wb_addr  out  ADDR_W  register-file write address (registered)
- wb_src  out  2  writeback mux select: 0 ALU, 1 MEM, 2 PC+8 (registered)

## Operation
- Destination decode, in priority order:
  - mem_op & ~write_op (load): rt, src MEM
  - alu_op & imm_op: rt, src ALU
  - jump_op & link_op & reg_jump_op (jalr): rd, src PC
  - jump_op & link_op: LINK_REG, src PC
  - alu_op: rd, src ALU
  - otherwise: no write
- Stores and non-linking jumps write nothing.
- A destination of 0 means no write.
- Source use:
  - rs is used by alu_op, mem_op and reg_jump_op.
  - rt is used by alu_op & ~imm_op and by mem_op & write_op.
- stall = issue_valid & (used source busy | destination busy (WAW) | port collision).
  - Port collision: the slot that the instruction's latency targets is already valid.
- Accept = issue_valid & ~stall. On accept with a write:
  - busy[dest] is set.
  - The entry {1, dest, src} is loaded into delay-line slot LAT-1.
- Delay line: MEM_LAT slots of {valid, addr, src}, shifting toward slot 0 every cycle. Slot 0 drives wb_*.
- At the edge where slot 0 is valid, busy[slot0.addr] clears.
- If the same edge also sets the same address, the set wins. This cannot occur under the WAW rule but must still hold.
- busy[0] is never set.

## Timing
- Reset: all busy bits 0, all slots invalid, wb_en=0, wb_addr=0, wb_src=0, stall=0 with issue_valid=0.
- An instruction accepted at edge t asserts wb_en during the cycle after edge t+LAT-1.
  - ALU/PC results: visible 1 cycle after accept (ALU_LAT=1).
  - Loads: visible 2 cycles after accept (MEM_LAT=2).
- A consumer of that register stalls until the cycle after wb_en is seen, because the register file writes at the edge.
- Reset asserted mid-operation drops all in-flight writes. wb_en is 0 in the first cycle after reset.
- stall has no effect when issue_valid=0, and no state changes on a stalled cycle except delay-line shift and busy clears.

## Structure
- Shared package `reg_wb_pkg`:
  - wb_src encodings (WB_ALU, WB_MEM, WB_PC)
  - delay-line entry struct
  - default LINK_REG
- Sub-module `dest_decode`: pure combinational decode of flags and fields into {we, addr, src, uses_rs, uses_rt}.
- The scoreboard and delay line stay in the top level.

## Test plan
- ALU add with rd=5, then an independent instruction: wb_en=1, wb_addr=5, wb_src=0 exactly one cycle after accept; busy[5] clears at that edge.
- Load to rt=8, immediately followed by an add reading rs=8: stall=1 for 2 cycles, accept on the third; wb_addr=8 with wb_src=1 precedes it.
- Load at t, then an independent ALU op at t+1 (both would write back at t+2): ALU op stalls one cycle by port collision; writebacks appear on consecutive cycles.
- jal, then jalr with rd=3: wb_addr=31 then 3, both wb_src=2; a store, an ALU op with rd=0 and a j each produce wb_en=0.
- Two loads back-to-back to rt=9: second stalls (WAW) until busy[9] clears; final writes to 9 appear in program order.
- Reset asserted while a load is in flight: wb_en=0 next cycle, busy all 0, and a following read of that register is not stalled.
